// File: rtl/arb_pkg.sv
// Shared types and helpers for the eight-way rotating-priority bus arbiter.
package arb_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index one below idx, wrapping 0 back to N-1.
    function automatic logic [IDX_W-1:0] dec_wrap(input logic [IDX_W-1:0] idx);
        return idx - IDX_W'(1);
    endfunction

endpackage

// File: rtl/rot_pri_enc.sv
// Combinational rotating-priority encoder: bit 'start' has top priority,
// then start-1, start-2, ... wrapping through 0 to N-1.
module rot_pri_enc
    import arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] pos;

    // rot[N-1] is req[start]; rot[gi] is req[start+gi+1], so the fixed
    // MSB-first search below walks start, start-1, ... in order.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign rot[gi] = req[start + IDX_W'(gi + 1)];
        end
    endgenerate

    always_comb begin
        pos   = '0;
        valid = |rot;
        for (int i = 0; i < N; i++) begin
            if (rot[i]) begin
                pos = IDX_W'(i);
            end
        end
        idx = valid ? (start + pos + IDX_W'(1)) : '0;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Eight-way arbiter with registered one-hot grant, hold timeout and a
// mandatory idle turnaround cycle between owners.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             rr_en,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_id
);

    localparam int HCNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam bit TIMEOUT_EN = (MAX_HOLD != 0);

    arb_state_t        state_reg, state_next;
    logic [N-1:0]      gnt_reg, gnt_next;
    logic [IDX_W-1:0]  gnt_id_reg, gnt_id_next;
    logic [IDX_W-1:0]  ptr_reg, ptr_next;
    logic [HCNT_W-1:0] hcnt_reg, hcnt_next;

    logic             enc_valid;
    logic [IDX_W-1:0] enc_idx;
    logic [IDX_W-1:0] enc_start;

    assign enc_start = rr_en ? ptr_reg : IDX_W'(N - 1);

    rot_pri_enc u_enc (
        .req   (req),
        .start (enc_start),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            gnt_reg    <= '0;
            gnt_id_reg <= '0;
            ptr_reg    <= IDX_W'(N - 1);
            hcnt_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            gnt_id_reg <= gnt_id_next;
            ptr_reg    <= ptr_next;
            hcnt_reg   <= hcnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        gnt_id_next = gnt_id_reg;
        ptr_next    = ptr_reg;
        hcnt_next   = hcnt_reg;
        case (state_reg)
            IDLE: begin
                if (enc_valid) begin
                    state_next  = GRANT;
                    gnt_next    = N'(1) << enc_idx;
                    gnt_id_next = enc_idx;
                    hcnt_next   = '0;
                    if (rr_en) begin
                        ptr_next = dec_wrap(enc_idx);
                    end
                end
            end
            GRANT: begin
                // Owner drop and timeout both return to IDLE, which forces the
                // one-cycle turnaround before anyone (including the owner) re-wins.
                if (!req[gnt_id_reg] || (TIMEOUT_EN && hcnt_reg == HOLD_LAST)) begin
                    state_next  = IDLE;
                    gnt_next    = '0;
                    gnt_id_next = '0;
                    hcnt_next   = '0;
                end else if (TIMEOUT_EN) begin
                    hcnt_next = hcnt_reg + HCNT_W'(1);
                end
            end
            default: begin
                state_next  = IDLE;
                gnt_next    = '0;
                gnt_id_next = '0;
                hcnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        gnt       = gnt_reg;
        gnt_id    = gnt_id_reg;
        gnt_valid = |gnt_reg;
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: one instance with MAX_HOLD=4 for the
// arbitration scenarios and one with MAX_HOLD=0 for the no-timeout case.
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rr_en;

    logic [7:0] gnt4, gnt0;
    logic       vld4, vld0;
    logic [2:0] id4, id0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       rr;
        logic [7:0] gnt;
        string      name;
    } vec_t;

    typedef struct {
        logic [7:0] gnt;
        int         sel;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl_a[$];
    vec_t tbl_b[$];

    rr_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rr_en     (rr_en),
        .gnt       (gnt4),
        .gnt_valid (vld4),
        .gnt_id    (id4)
    );

    rr_arbiter #(.MAX_HOLD(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rr_en     (rr_en),
        .gnt       (gnt0),
        .gnt_valid (vld0),
        .gnt_id    (id0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] idx_of(input logic [7:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic check_one();
        exp_t       e;
        logic [7:0] ag;
        logic [2:0] ai;
        logic       av;
        e  = exp_q.pop_front();
        ag = (e.sel == 0) ? gnt0 : gnt4;
        ai = (e.sel == 0) ? id0  : id4;
        av = (e.sel == 0) ? vld0 : vld4;
        total++;
        if (ag !== e.gnt || ai !== idx_of(e.gnt) || av !== (|e.gnt)) begin
            bad++;
            $display("FAIL %s: got gnt=%02h id=%0d valid=%0b want gnt=%02h id=%0d valid=%0b",
                     e.name, ag, ai, av, e.gnt, idx_of(e.gnt), |e.gnt);
        end else begin
            $display("ok   %s: gnt=%02h id=%0d valid=%0b", e.name, ag, ai, av);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then
    // compare once the edge has registered them.
    task automatic step(input logic s_rst, input logic [7:0] s_req, input logic s_rr,
                        input logic [7:0] e_gnt, input int sel, input string nm);
        @(negedge clk);
        rst   = s_rst;
        req   = s_req;
        rr_en = s_rr;
        exp_q.push_back('{gnt: e_gnt, sel: sel, name: nm});
        @(posedge clk);
        #1;
        check_one();
    endtask

    initial begin
        rst   = 1'b1;
        req   = 8'h00;
        rr_en = 1'b0;

        // Reset, fixed priority and release/re-grant with turnaround.
        tbl_a.push_back('{1'b1, 8'h00, 1'b0, 8'h00, "reset"});
        tbl_a.push_back('{1'b1, 8'hFF, 1'b1, 8'h00, "reset_with_req"});
        tbl_a.push_back('{1'b0, 8'h00, 1'b0, 8'h00, "idle_noreq"});
        tbl_a.push_back('{1'b0, 8'h05, 1'b0, 8'h04, "fix_grant2"});
        tbl_a.push_back('{1'b0, 8'h01, 1'b0, 8'h00, "fix_release2"});
        tbl_a.push_back('{1'b0, 8'h01, 1'b0, 8'h01, "fix_grant0"});
        tbl_a.push_back('{1'b0, 8'h01, 1'b0, 8'h01, "fix_hold0"});
        tbl_a.push_back('{1'b0, 8'h00, 1'b0, 8'h00, "fix_release0"});

        // Owner drops while others request; pointer wrap 0 -> 7.
        tbl_b.push_back('{1'b0, 8'h42, 1'b1, 8'h40, "rr_grant6"});
        tbl_b.push_back('{1'b0, 8'h03, 1'b1, 8'h00, "owner_drop_turnaround"});
        tbl_b.push_back('{1'b0, 8'h03, 1'b1, 8'h02, "rr_next_from_ptr5"});
        tbl_b.push_back('{1'b0, 8'h00, 1'b1, 8'h00, "rel1"});
        tbl_b.push_back('{1'b0, 8'h81, 1'b1, 8'h01, "rr_ptr0_grant0"});
        tbl_b.push_back('{1'b0, 8'h00, 1'b1, 8'h00, "rel0"});
        tbl_b.push_back('{1'b0, 8'h81, 1'b1, 8'h80, "ptr_wrapped_to7"});
        tbl_b.push_back('{1'b0, 8'h00, 1'b1, 8'h00, "rel7"});

        foreach (tbl_a[i])
            step(tbl_a[i].rst, tbl_a[i].req, tbl_a[i].rr, tbl_a[i].gnt, 4, tbl_a[i].name);

        // Round-robin rotation with all requesters active.
        begin
            int owners[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
            foreach (owners[k]) begin
                for (int c = 0; c < 4; c++)
                    step(1'b0, 8'hFF, 1'b1, 8'(1 << owners[k]), 4,
                         $sformatf("rr_owner%0d_c%0d", owners[k], c));
                step(1'b0, 8'hFF, 1'b1, 8'h00, 4, $sformatf("rr_turn_after%0d", owners[k]));
            end
        end

        // Fixed mode: requester 7 always wins, pointer (now 6) untouched.
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++)
                step(1'b0, 8'hFF, 1'b0, 8'h80, 4, $sformatf("fix_starve_r%0d_c%0d", k, c));
            step(1'b0, 8'hFF, 1'b0, 8'h00, 4, $sformatf("fix_starve_turn%0d", k));
        end

        // Back to round-robin: pointer 6 survived fixed mode; reset mid-grant.
        step(1'b0, 8'hFF, 1'b1, 8'h40, 4, "rr_resume_grant6");
        step(1'b0, 8'hFF, 1'b1, 8'h40, 4, "rr_hold6");
        step(1'b1, 8'hFF, 1'b1, 8'h00, 4, "reset_mid_grant");
        step(1'b0, 8'hFF, 1'b1, 8'h80, 4, "post_reset_ptr7");
        step(1'b0, 8'h00, 1'b1, 8'h00, 4, "post_reset_release");

        foreach (tbl_b[i])
            step(tbl_b[i].rst, tbl_b[i].req, tbl_b[i].rr, tbl_b[i].gnt, 4, tbl_b[i].name);

        // Timeout disabled: grant never drops while the owner keeps requesting.
        for (int c = 0; c < 100; c++)
            step(1'b0, 8'h30, 1'b0, 8'h20, 0, $sformatf("nohold_c%0d", c));
        step(1'b0, 8'h00, 1'b0, 8'h00, 0, "nohold_release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
